prbs31_checker: RTL and testbench
=================================

PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 Parameter WORDWIDTH, default 15: received word width in bits per clock.
REQ-002 Parameter LOCKWORDS, default 4: number of consecutive error-free words needed in VERIFY before lock.
REQ-003 Parameter UNLOCKWORDS, default 8: number of consecutive errored words in LOCKED that force a return to HUNT.
REQ-004 Port clkTMR, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetTMR, input, 1: asynchronous, active-high reset.
REQ-006 Port disTMR, input, 1: high freezes all internal state and outputs.
REQ-007 Port dataTMR, input, WORDWIDTH: received PRBS31 word; bit 0 is the earliest bit in time (LSB first).
REQ-008 Port clrErrTMR, input, 1: synchronous clear of errCntTMR.
REQ-009 Port lockedTMR, output, 1: checker is aligned to the stream.
REQ-010 Port errFlagTMR, output, 1: registered; high when the last word checked in LOCKED held at least one bit error.
REQ-011 Port errCntTMR, output, 16: saturating count of bit errors seen while LOCKED.

Function
REQ-012 The sequence recurrence is b[n] = b[n-31] XOR b[n-28] (x^31+x^28+1), matching the PRBS31 generator's LSB-first word order.
REQ-013 The FSM has three states: HUNT, VERIFY and LOCKED. The reset state is HUNT.
REQ-014 HUNT: each word with disTMR=0 shifts into a 31-bit history register.
- After ceil(31/WORDWIDTH) words (3 words at default), the most recent 31 bits seed the predictor and the FSM moves to VERIFY.
REQ-015 VERIFY: each word is compared with the predicted word.
- A mismatch returns the FSM to HUNT and clears the word counter.
- LOCKWORDS consecutive matches move the FSM to LOCKED.
REQ-016 The predictor advances WORDWIDTH steps per accepted word. In VERIFY and LOCKED it advances from its own state, never from received data, so that errors do not propagate.
REQ-017 LOCKED: the error vector is dataTMR XOR the predicted word.
- errFlagTMR is set to the OR of the error vector one cycle after the word is sampled.
- errCntTMR is incremented by the popcount of the error vector in the same cycle.
REQ-018 errCntTMR saturates at 16'hFFFF and never wraps.
REQ-019 If clrErrTMR is high in the same cycle as an increment, clear wins and errCntTMR becomes 0.
REQ-020 LOCKED: an error-free word resets the bad-word run counter.
- When the run counter reaches UNLOCKWORDS, lockedTMR falls on the next edge and the FSM enters HUNT.
- errCntTMR holds its value through this transition.
REQ-021 lockedTMR is high only in LOCKED, registered. errFlagTMR is 0 in HUNT and VERIFY.
REQ-022 disTMR=1 holds the FSM, predictor, counters and outputs unchanged. clrErrTMR is still honoured while disTMR=1.

Reset
REQ-023 While resetTMR is high, the following are 0 immediately, independent of clkTMR: state=HUNT, history, predictor, word counter, run counter, lockedTMR, errFlagTMR, errCntTMR.
REQ-024 Reset asserted mid-LOCKED aborts the lock. After release, lock acquisition restarts from HUNT.

Structure
REQ-025 A shared include file holds the following constants, for use by both this block and the PRBS31 generator:
- polynomial taps (31, 28);
- state encodings HUNT, VERIFY, LOCKED;
- the 16-bit counter width.
REQ-026 A combinational sub-module prbs31_step computes the next 31-bit state and WORDWIDTH-bit output word from the current state. It is shared with the generator.

Verification
REQ-027 Clean stream: generator (WORDWIDTH=15, seed 31'h2AAAAAAA) -> dataTMR, reset released -> lockedTMR high after the 7th sampled word edge (3 HUNT + 4 VERIFY); errCntTMR=0 after 20000 cycles.
REQ-028 Single flip of bit 5 in word 200 while locked -> errFlagTMR high for exactly one cycle; errCntTMR=1; lock is held.
REQ-029 Flip of bits 0, 7 and 14 in one word -> errCntTMR rises by 3. A simultaneous clrErrTMR pulse -> errCntTMR=0.
REQ-030 8 consecutive words with a one-bit error -> lockedTMR falls after the 8th word. With a clean stream, relock follows 7 words later; errCntTMR=8 is retained.
REQ-031 Saturation: preload errCntTMR near the limit through a forced error burst -> errCntTMR stops at 16'hFFFF.
REQ-032 Freeze and reset: disTMR high for 50 cycles while locked -> no output change. resetTMR pulsed mid-lock -> all outputs 0 asynchronously, followed by relock.

Source files
------------

// File: rtl/prbs31_pkg.sv
// Constants shared by the PRBS31 checker and the PRBS31 generator.
package prbs31_pkg;

   // x^31 + x^28 + 1
   localparam int PRBS_LEN = 31;
   localparam int TAP_A    = 31;
   localparam int TAP_B    = 28;

   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

endpackage

// File: rtl/prbs31_step.sv
// Advances a PRBS31 state by WORDWIDTH bits and returns those bits as a word,
// earliest bit in word[0]. The state holds the last 31 bits, oldest in bit 0.
module prbs31_step
   import prbs31_pkg::*;
#(
   parameter int WORDWIDTH = 15
) (
   input  logic [PRBS_LEN-1:0]  state,
   output logic [PRBS_LEN-1:0]  state_next,
   output logic [WORDWIDTH-1:0] word
);

   // unrolled recurrence b[n] = b[n-31] ^ b[n-28], one bit per iteration
   always_comb begin
      state_next = state;
      word       = '0;
      for (int k = 0; k < WORDWIDTH; k++) begin
         word[k]    = state_next[PRBS_LEN-TAP_A] ^ state_next[PRBS_LEN-TAP_B];
         state_next = {word[k], state_next[PRBS_LEN-1:1]};
      end
   end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: hunts for alignment, verifies, then counts bit
// errors against a free-running predictor while locked.
//
// state  | meaning
// -------+--------------------------------------------------------------
// HUNT   | shifting received words into the history until 31 bits known
// VERIFY | comparing received words with the predictor, no errors allowed
// LOCKED | aligned; counting bit errors, leaving after a run of bad words
module prbs31_checker
   import prbs31_pkg::*;
#(
   parameter int WORDWIDTH   = 15,
   parameter int LOCKWORDS   = 4,
   parameter int UNLOCKWORDS = 8
) (
   input  logic                 clkTMR,
   input  logic                 resetTMR,
   input  logic                 disTMR,
   input  logic [WORDWIDTH-1:0] dataTMR,
   input  logic                 clrErrTMR,
   output logic                 lockedTMR,
   output logic                 errFlagTMR,
   output logic [CNT_W-1:0]     errCntTMR
);

   localparam int HUNTWORDS = (PRBS_LEN + WORDWIDTH - 1) / WORDWIDTH;
   localparam int WCNT_MAX  = (HUNTWORDS > LOCKWORDS) ? HUNTWORDS : LOCKWORDS;
   localparam int WCNT_W    = $clog2(WCNT_MAX + 1);
   localparam int RCNT_W    = $clog2(UNLOCKWORDS + 1);

   localparam logic [WCNT_W-1:0] HUNT_LAST   = WCNT_W'(HUNTWORDS - 1);
   localparam logic [WCNT_W-1:0] LOCK_LAST   = WCNT_W'(LOCKWORDS - 1);
   localparam logic [RCNT_W-1:0] UNLOCK_LAST = RCNT_W'(UNLOCKWORDS - 1);

   prbs_state_e                      state_q, state_n;
   logic [PRBS_LEN-1:0]              hist_q, hist_shift;
   logic [WORDWIDTH+PRBS_LEN-1:0]    hist_cat;
   logic [PRBS_LEN-1:0]              pred_q, pred_next;
   logic [WORDWIDTH-1:0]             pred_word;
   logic [WCNT_W-1:0]                word_cnt_q, word_cnt_n;
   logic [RCNT_W-1:0]                run_cnt_q, run_cnt_n;
   logic [WORDWIDTH-1:0]             err_vec;
   logic                             err_any;
   logic [CNT_W:0]                   err_pop;
   logic [CNT_W:0]                   cnt_sum;
   logic [CNT_W-1:0]                 cnt_sat;

   prbs31_step #(
      .WORDWIDTH (WORDWIDTH)
   ) u_step (
      .state      (pred_q),
      .state_next (pred_next),
      .word       (pred_word)
   );

   // newest word enters at the top of the history, oldest bits fall off bit 0
   assign hist_cat   = {dataTMR, hist_q} >> WORDWIDTH;
   assign hist_shift = hist_cat[PRBS_LEN-1:0];

   assign err_vec = dataTMR ^ pred_word;
   assign err_any = |err_vec;

   // popcount of the error vector
   always_comb begin
      err_pop = '0;
      for (int i = 0; i < WORDWIDTH; i++) begin
         err_pop = err_pop + {{CNT_W{1'b0}}, err_vec[i]};
      end
   end

   assign cnt_sum = {1'b0, errCntTMR} + err_pop;
   assign cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

   // next-state and word/run counter decode; disTMR holds everything
   always_comb begin
      state_n    = state_q;
      word_cnt_n = word_cnt_q;
      run_cnt_n  = run_cnt_q;
      if (!disTMR) begin
         unique case (state_q)
            HUNT: begin
               if (word_cnt_q == HUNT_LAST) begin
                  state_n    = VERIFY;
                  word_cnt_n = '0;
               end else begin
                  word_cnt_n = word_cnt_q + 1'b1;
               end
            end
            VERIFY: begin
               if (err_any) begin
                  state_n    = HUNT;
                  word_cnt_n = '0;
               end else if (word_cnt_q == LOCK_LAST) begin
                  state_n    = LOCKED;
                  word_cnt_n = '0;
               end else begin
                  word_cnt_n = word_cnt_q + 1'b1;
               end
            end
            LOCKED: begin
               if (!err_any) begin
                  run_cnt_n = '0;
               end else if (run_cnt_q == UNLOCK_LAST) begin
                  state_n   = HUNT;
                  run_cnt_n = '0;
               end else begin
                  run_cnt_n = run_cnt_q + 1'b1;
               end
            end
            default: begin
               state_n    = HUNT;
               word_cnt_n = '0;
               run_cnt_n  = '0;
            end
         endcase
      end
   end

   // FSM, counters, history and predictor registers
   always_ff @(posedge clkTMR or posedge resetTMR) begin
      if (resetTMR) begin
         state_q    <= HUNT;
         word_cnt_q <= '0;
         run_cnt_q  <= '0;
         hist_q     <= '0;
         pred_q     <= '0;
      end else begin
         state_q    <= state_n;
         word_cnt_q <= word_cnt_n;
         run_cnt_q  <= run_cnt_n;
         if (!disTMR) begin
            if (state_q == HUNT) begin
               hist_q <= hist_shift;
               if (word_cnt_q == HUNT_LAST) begin
                  pred_q <= hist_shift;
               end
            end else begin
               // predictor free-runs so received errors never reach it
               pred_q <= pred_next;
            end
         end
      end
   end

   // registered status outputs; the flag is cleared on the edge that unlocks
   always_ff @(posedge clkTMR or posedge resetTMR) begin
      if (resetTMR) begin
         lockedTMR  <= 1'b0;
         errFlagTMR <= 1'b0;
      end else if (!disTMR) begin
         lockedTMR  <= (state_n == LOCKED);
         errFlagTMR <= (state_q == LOCKED) && (state_n == LOCKED) && err_any;
      end
   end

   // saturating error counter; clear wins and works even while frozen
   always_ff @(posedge clkTMR or posedge resetTMR) begin
      if (resetTMR) begin
         errCntTMR <= '0;
      end else if (clrErrTMR) begin
         errCntTMR <= '0;
      end else if (!disTMR && state_q == LOCKED) begin
         errCntTMR <= cnt_sat;
      end
   end

endmodule

// File: tb/tb_prbs31_checker.sv
// Testbench for prbs31_checker: PRBS31 stream from a bit-level recurrence,
// error injection with a word-level error/lock model.
module tb_prbs31_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        dis;
   logic [14:0] data;
   logic        clr;
   logic        locked;
   logic        flag;
   logic [15:0] cnt;

   int checks = 0;
   int errors = 0;
   int wi     = 0;          // words delivered to the checker
   int m_cnt  = 0;          // modelled error count

   bit gen_q[$];            // last 31 stream bits, oldest first

   prbs31_checker dut (
      .clkTMR     (clk),
      .resetTMR   (rst),
      .disTMR     (dis),
      .dataTMR    (data),
      .clrErrTMR  (clr),
      .lockedTMR  (locked),
      .errFlagTMR (flag),
      .errCntTMR  (cnt)
   );

   always #5 clk = ~clk;

   function automatic int sat_add(input int a, input int b);
      return (a + b > 65535) ? 65535 : a + b;
   endfunction

   // next 15 clean stream bits, b[n] = b[n-31] ^ b[n-28], earliest in bit 0
   task automatic next_clean(output logic [14:0] w);
      bit nb;
      for (int k = 0; k < 15; k++) begin
         nb = gen_q[0] ^ gen_q[3];
         gen_q.push_back(nb);
         void'(gen_q.pop_front());
         w[k] = nb;
      end
   endtask

   // present one word (clean ^ flip) for one edge, then sit 1 time unit after it
   task automatic drive(input logic [14:0] flip, input logic clr_v);
      logic [14:0] w;
      next_clean(w);
      data = w ^ flip;
      clr  = clr_v;
      @(posedge clk);
      #1;
      clr = 1'b0;
      wi++;
   endtask

   task automatic test_reset;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", flag); end
      checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", cnt); end
   endtask

   task automatic test_lock_acquire;
      for (int i = 1; i <= 7; i++) begin
         drive('0, 1'b0);
         checks++;
         if (locked !== (i >= 7)) begin
            errors++; $display("FAIL acquire_locked word %0d: got %b expected %b", i, locked, (i >= 7));
         end
      end
      while (wi < 199) begin
         drive('0, 1'b0);
         checks++;
         if (locked !== 1'b1 || flag !== 1'b0 || cnt !== 16'h0) begin
            errors++; $display("FAIL clean_pre word %0d: got locked=%b flag=%b cnt=%h expected 1 0 0000", wi, locked, flag, cnt);
         end
      end
   endtask

   task automatic test_single_flip;
      drive(15'h0020, 1'b0);           // word 200, bit 5
      m_cnt = 1;
      checks++; if (flag !== 1'b1) begin errors++; $display("FAIL single_flag_hi: got %b expected 1", flag); end
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", cnt); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b expected 1", locked); end
      drive('0, 1'b0);
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL single_flag_lo: got %b expected 0", flag); end
   endtask

   task automatic test_clean_run;
      while (wi < 20000) begin
         drive('0, 1'b0);
         checks++;
         if (locked !== 1'b1 || flag !== 1'b0 || cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL clean_run word %0d: got locked=%b flag=%b cnt=%0d expected 1 0 %0d", wi, locked, flag, cnt, m_cnt);
         end
      end
   endtask

   task automatic test_triple_flip;
      drive(15'h4081, 1'b0);
      m_cnt = sat_add(m_cnt, 3);
      checks++; if (cnt !== 16'(m_cnt)) begin errors++; $display("FAIL triple_cnt: got %0d expected %0d", cnt, m_cnt); end
      checks++; if (flag !== 1'b1) begin errors++; $display("FAIL triple_flag: got %b expected 1", flag); end
      drive(15'h4081, 1'b1);
      m_cnt = 0;
      checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL triple_clr_cnt: got %0d expected 0", cnt); end
      checks++; if (flag !== 1'b1) begin errors++; $display("FAIL triple_clr_flag: got %b expected 1", flag); end
   endtask

   task automatic test_random_errors;
      logic [14:0] flip;
      logic        c;
      int          run = 0;
      for (int i = 0; i < 300; i++) begin
         flip = ($urandom_range(0, 3) == 0 && run < 5) ? 15'($urandom) : 15'h0;
         c    = ($urandom_range(0, 15) == 0);
         run  = (flip != 0) ? run + 1 : 0;
         drive(flip, c);
         m_cnt = c ? 0 : sat_add(m_cnt, $countones(flip));
         checks++;
         if (locked !== 1'b1 || flag !== (flip != 0) || cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL random word %0d flip %h clr %b: got locked=%b flag=%b cnt=%0d expected 1 %b %0d",
                               wi, flip, c, locked, flag, cnt, (flip != 0), m_cnt);
         end
      end
   endtask

   task automatic test_unlock_relock;
      drive('0, 1'b1);
      m_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         drive(15'(1 << $urandom_range(0, 14)), 1'b0);
         m_cnt++;
         checks++;
         if (locked !== (i < 8)) begin
            errors++; $display("FAIL unlock_locked bad word %0d: got %b expected %b", i, locked, (i < 8));
         end
      end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL unlock_flag: got %b expected 0", flag); end
      checks++; if (cnt !== 16'd8) begin errors++; $display("FAIL unlock_cnt: got %0d expected 8", cnt); end
      for (int i = 1; i <= 7; i++) begin
         drive('0, 1'b0);
         checks++;
         if (locked !== (i >= 7) || cnt !== 16'd8) begin
            errors++; $display("FAIL relock word %0d: got locked=%b cnt=%0d expected %b 8", i, locked, cnt, (i >= 7));
         end
      end
   endtask

   task automatic test_saturation;
      logic [14:0] flip;
      int          extra = 0;
      int          k = 0;
      while (extra < 24 && k < 8000) begin
         flip = (k % 8 == 7) ? 15'h0 : 15'h7fff;
         drive(flip, 1'b0);
         m_cnt = sat_add(m_cnt, $countones(flip));
         if (m_cnt == 65535) extra++;
         checks++;
         if (cnt !== 16'(m_cnt) || locked !== 1'b1) begin
            errors++; $display("FAIL sat word %0d: got cnt=%h locked=%b expected %h 1", k, cnt, locked, 16'(m_cnt));
         end
         k++;
      end
      checks++; if (cnt !== 16'hffff) begin errors++; $display("FAIL sat_final: got %h expected ffff", cnt); end
   endtask

   task automatic test_freeze;
      drive(15'h0004, 1'b0);
      m_cnt = sat_add(m_cnt, 1);
      dis = 1'b1;
      for (int i = 0; i < 50; i++) begin
         data = 15'($urandom);
         @(posedge clk); #1;
         checks++;
         if (locked !== 1'b1 || flag !== 1'b1 || cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL freeze cycle %0d: got locked=%b flag=%b cnt=%h expected 1 1 %h", i, locked, flag, cnt, 16'(m_cnt));
         end
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      m_cnt = 0;
      checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL freeze_clr_cnt: got %h expected 0000", cnt); end
      checks++; if (flag !== 1'b1) begin errors++; $display("FAIL freeze_clr_flag: got %b expected 1", flag); end
      dis = 1'b0;
      drive('0, 1'b0);
      checks++;
      if (locked !== 1'b1 || flag !== 1'b0 || cnt !== 16'h0) begin
         errors++; $display("FAIL freeze_resume: got locked=%b flag=%b cnt=%h expected 1 0 0000", locked, flag, cnt);
      end
   endtask

   task automatic test_reset_midlock;
      drive(15'h0100, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (locked !== 1'b0 || flag !== 1'b0 || cnt !== 16'h0) begin
         errors++; $display("FAIL async_reset: got locked=%b flag=%b cnt=%h expected 0 0 0000", locked, flag, cnt);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         drive('0, 1'b0);
         checks++;
         if (locked !== (i >= 7) || cnt !== 16'h0) begin
            errors++; $display("FAIL reset_relock word %0d: got locked=%b cnt=%h expected %b 0000", i, locked, cnt, (i >= 7));
         end
      end
   endtask

   initial begin
      logic [30:0] seed;
      seed = 31'h2AAAAAAA;
      for (int i = 0; i < 31; i++) gen_q.push_back(seed[i]);
      rst  = 1'b1;
      dis  = 1'b0;
      clr  = 1'b0;
      data = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      rst = 1'b0;
      test_lock_acquire;
      test_single_flip;
      test_clean_run;
      test_triple_flip;
      test_random_errors;
      test_unlock_relock;
      test_saturation;
      test_freeze;
      test_reset_midlock;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
